// File: rtl/isw_and_scheduler_if.sv
// Bundle of the requester, PRNG, gadget and response buses of the ISW AND scheduler.
// The scheduler is the slave. The master side is the requesters, the PRNG and the gadget together.
// Every signal is a plain wire. No storage lives in the interface.
interface isw_and_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1
);
  // Requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a0;
  logic [NUM_REQ*WIDTH-1:0] req_a1;
  logic [NUM_REQ*WIDTH-1:0] req_b0;
  logic [NUM_REQ*WIDTH-1:0] req_b1;

  // PRNG side
  logic                     rnd_valid;
  logic                     rnd_ready;
  logic [WIDTH-1:0]         rnd_data;

  // Gadget side
  logic [WIDTH-1:0]         g_a0;
  logic [WIDTH-1:0]         g_a1;
  logic [WIDTH-1:0]         g_b0;
  logic [WIDTH-1:0]         g_b1;
  logic [WIDTH-1:0]         g_r;
  logic [WIDTH-1:0]         g_c0;
  logic [WIDTH-1:0]         g_c1;

  // Response side
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_c0;
  logic [WIDTH-1:0]         resp_c1;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1,
    output rnd_valid, rnd_data,
    output g_c0, g_c1,
    input  req_ready, rnd_ready,
    input  g_a0, g_a1, g_b0, g_b1, g_r,
    input  resp_valid, resp_c0, resp_c1
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1,
    input  rnd_valid, rnd_data,
    input  g_c0, g_c1,
    output req_ready, rnd_ready,
    output g_a0, g_a1, g_b0, g_b1, g_r,
    output resp_valid, resp_c0, resp_c1
  );
endinterface

// File: rtl/isw_and_scheduler.sv
// Round-robin scheduler that shares one pipelined 2-share ISW AND gadget, with fresh randomness buffered per operation.
// Latency: a result is reported LAT+1 cycles after the accept edge, which is 4 cycles with the defaults.
// Backpressure: req_ready needs en and a non-empty random FIFO. rnd_ready = !full. Responses cannot be stalled.
module isw_and_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 1,
  parameter int LAT       = 3,
  parameter int RND_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,      // asynchronous, active low
  input  logic                        en,
  isw_and_scheduler_if.slave          bus,
  output logic                        busy,
  output logic [$clog2(RND_DEPTH):0]  rnd_level
);
  localparam int AW = $clog2(RND_DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(RND_DEPTH);

  // Random-word FIFO state
  logic [WIDTH-1:0] fifo_mem [RND_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             push;

  // Arbitration state
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    cand;
  logic             cand_found;
  logic             issue;
  int               idx;

  // Tag pipeline: stage s holds the requester of the operation accepted s edges ago
  logic [LAT:0]     tag_vld;
  logic [PW-1:0]    tag_id [LAT+1];

  assign fifo_empty    = (count == '0);
  assign bus.rnd_ready = (count != FULL_LVL);
  assign push          = bus.rnd_valid & bus.rnd_ready;
  assign issue         = en & cand_found & ~fifo_empty;
  assign busy          = |tag_vld;
  assign rnd_level     = count;

  // Store pushed random words. Contents are only read behind a valid count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.rnd_data;
  end

  // FIFO pointers and occupancy. A pop only happens on issue, which needs the FIFO non-empty before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    end
  end

  // Candidate selection: first valid requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!cand_found && bus.req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = PW'(idx);
      end
    end
  end

  // Accept strobe. It only goes to the selected requester and does not depend on operand values.
  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[cand] = 1'b1;
  end

  // Round-robin pointer moves past the requester just served and holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(cand) == NUM_REQ - 1) ? '0 : cand + 1'b1;
    end
  end

  // Gadget input registers. Each share has its own mux so share 0 and share 1 never meet. Idle cycles drive zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.g_a0 <= '0;
      bus.g_a1 <= '0;
      bus.g_b0 <= '0;
      bus.g_b1 <= '0;
      bus.g_r  <= '0;
    end else if (issue) begin
      bus.g_a0 <= bus.req_a0[int'(cand)*WIDTH +: WIDTH];
      bus.g_a1 <= bus.req_a1[int'(cand)*WIDTH +: WIDTH];
      bus.g_b0 <= bus.req_b0[int'(cand)*WIDTH +: WIDTH];
      bus.g_b1 <= bus.req_b1[int'(cand)*WIDTH +: WIDTH];
      bus.g_r  <= fifo_mem[rd_ptr];
    end else begin
      bus.g_a0 <= '0;
      bus.g_a1 <= '0;
      bus.g_b0 <= '0;
      bus.g_b1 <= '0;
      bus.g_r  <= '0;
    end
  end

  // Tag shift register, kept in lockstep with the gadget pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-1:0], issue};
      tag_id[0] <= cand;
      for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  // Capture the gadget result for the owning requester. The result shares hold between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.resp_valid <= '0;
      bus.resp_c0    <= '0;
      bus.resp_c1    <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (tag_vld[LAT]) begin
        bus.resp_valid[tag_id[LAT]] <= 1'b1;
        bus.resp_c0 <= bus.g_c0;
        bus.resp_c1 <= bus.g_c1;
      end
    end
  end
endmodule

// File: tb/tb_isw_and_scheduler.sv
// Testbench for isw_and_scheduler. It uses randomized stimulus, a reference model and a scoreboard of expected responses.
// A behavioural 3-cycle ISW gadget closes the loop. A separate monitor checks every response cycle.
// The bench always terminates on its own with a fixed cycle count.
module tb_isw_and_scheduler;
  localparam int NREQ  = 4;
  localparam int W     = 1;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int   id;
    logic c0;
    logic c1;
    int   due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       busy;
  logic [2:0] rnd_level;

  isw_and_scheduler_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus();

  isw_and_scheduler #(.NUM_REQ(NREQ), .WIDTH(W), .LAT(LAT), .RND_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .rnd_level (rnd_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ISW AND gadget with 3 register stages
  logic s1_c0 = 1'b0, s1_c1 = 1'b0, s2_c0 = 1'b0, s2_c1 = 1'b0;
  initial begin
    bus.g_c0 = 1'b0;
    bus.g_c1 = 1'b0;
  end
  always @(posedge clk) begin
    s1_c0 <= (bus.g_a0 & bus.g_b0) ^ bus.g_r;
    s1_c1 <= (bus.g_a1 & bus.g_b1) ^ ((bus.g_r ^ (bus.g_a0 & bus.g_b1)) ^ (bus.g_a1 & bus.g_b0));
    s2_c0 <= s1_c0;
    s2_c1 <= s1_c1;
    bus.g_c0 <= s2_c0;
    bus.g_c1 <= s2_c1;
  end

  // Reference model state
  exp_t       sbq[$];
  logic       rndq[$];
  int         ptr_m      = 0;
  int         last_issue = -100;
  logic [4:0] gexp       = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle's response strobe and shares against the head of the scoreboard
  logic [NREQ-1:0] mon_exp_v;
  exp_t            mon_e;
  always @(negedge clk) begin
    mon_exp_v = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      mon_exp_v[mon_e.id] = 1'b1;
      chk("resp_valid", bus.resp_valid, mon_exp_v);
      chk("resp_c0", bus.resp_c0, mon_e.c0);
      chk("resp_c1", bus.resp_c1, mon_e.c1);
      chk("resp_product", bus.resp_c0 ^ bus.resp_c1,
          (bus.g_a0 === 1'bx) ? 1'b0 : (mon_e.c0 ^ mon_e.c1));
    end else begin
      chk("resp_valid_idle", bus.resp_valid, mon_exp_v);
    end
  end

  task automatic rand_ops();
    bus.req_a0 = 4'($urandom);
    bus.req_a1 = 4'($urandom);
    bus.req_b0 = 4'($urandom);
    bus.req_b1 = 4'($urandom);
  endtask

  // Check the visible state, then predict what the coming edge does
  task automatic model_step();
    int   lvl;
    int   cand;
    int   j;
    bit   found;
    bit   iss;
    logic r, a0, a1, b0, b1;
    exp_t e;
    lvl = rndq.size();
    chk("rnd_level", rnd_level, lvl);
    chk("rnd_ready", bus.rnd_ready, lvl < DEPTH);
    chk("busy", busy, (cyc - last_issue) <= LAT);
    chk("g_inputs", {bus.g_a0, bus.g_a1, bus.g_b0, bus.g_b1, bus.g_r}, gexp);
    found = 0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr_m + k) % NREQ;
      if (!found && bus.req_valid[j]) begin
        found = 1;
        cand  = j;
      end
    end
    iss = en && found && (lvl > 0);
    chk("req_ready", bus.req_ready, iss ? (1 << cand) : 0);
    if (iss) begin
      r  = rndq.pop_front();
      a0 = bus.req_a0[cand];
      a1 = bus.req_a1[cand];
      b0 = bus.req_b0[cand];
      b1 = bus.req_b1[cand];
      e.id  = cand;
      e.c0  = (a0 & b0) ^ r;
      e.c1  = (a1 & b1) ^ (r ^ (a0 & b1)) ^ (a1 & b0);
      e.due = cyc + LAT + 2;
      sbq.push_back(e);
      ptr_m      = (cand + 1) % NREQ;
      last_issue = cyc + 1;
      gexp       = {a0, a1, b0, b1, r};
    end else begin
      gexp = '0;
    end
    if (bus.rnd_valid && lvl < DEPTH) rndq.push_back(bus.rnd_data);
  endtask

  // Called one time unit after a rising edge. It drives the inputs, checks and models, then advances one cycle.
  task automatic do_cycle(input logic e, input logic [3:0] rv, input logic pv);
    en            = e;
    bus.req_valid = rv;
    bus.rnd_valid = pv;
    bus.rnd_data  = 1'($urandom);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_c", {bus.resp_c0, bus.resp_c1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rnd_level", rnd_level, 0);
    chk("rst_g", {bus.g_a0, bus.g_a1, bus.g_b0, bus.g_b1, bus.g_r}, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rnd_ready", bus.rnd_ready, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 4'b0000, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data = '0;
    rand_ops();
    #3;
    check_reset_outputs();
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIFO boundaries: five pushes into a depth-4 FIFO, then a pop+push at full-1
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 4'b0000, 1'b1);
    rand_ops();
    do_cycle(1'b1, 4'b0001, 1'b0);
    do_cycle(1'b1, 4'b0001, 1'b1);
    do_cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      do_cycle(1'b1, 4'b1111, 1'b0);
    end

    // Randomness starvation
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4'b0001, 1'b0);
    do_cycle(1'b1, 4'b0001, 1'b1);
    do_cycle(1'b1, 4'b0001, 1'b0);
    do_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) do_cycle(1'b1, 4'b0011, 1'b0);
    idle(6);

    // Single op on requester 2: a=(1,0), b=(0,1)
    do_cycle(1'b1, 4'b0000, 1'b1);
    bus.req_a0 = 4'b0100;
    bus.req_a1 = 4'b0000;
    bus.req_b0 = 4'b0000;
    bus.req_b1 = 4'b0100;
    do_cycle(1'b1, 4'b0100, 1'b0);
    idle(6);

    // Round-robin fairness with the FIFO kept topped up
    do_cycle(1'b1, 4'b0000, 1'b1);
    do_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      do_cycle(1'b1, 4'b1111, 1'b1);
    end
    idle(6);

    // en gating: two ops, then en low with requests pending, then en rising
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      do_cycle(1'b1, 4'b1111, 1'b0);
    end
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 4'b1111, 1'b0);
    rand_ops();
    do_cycle(1'b1, 4'b1111, 1'b0);
    idle(6);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      do_cycle(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
    end
    idle(6);

    // Asynchronous reset with three operations in flight
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      do_cycle(1'b1, 4'b1111, 1'b1);
    end
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    rndq.delete();
    ptr_m      = 0;
    last_issue = -100;
    gexp       = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // The pointer restarts at requester 0
    do_cycle(1'b1, 4'b0000, 1'b1);
    do_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      do_cycle(1'b1, 4'b1111, 1'b0);
    end
    idle(8);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/isw_and_scheduler.md
Name: isw_and_scheduler

Overview:
- Shares one pipelined first-order (2-share) ISW AND gadget between NUM_REQ requesters.
- Buffers fresh randomness from the PRNG and issues at most one operation per cycle, round-robin.
- Consumes exactly one fresh WIDTH-bit random word per operation, never reused.
- Routes each result back to its issuer using a tag pipeline matched to the gadget latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 1, bits per share, i.e. parallel gadget lanes.
- LAT, 3, gadget latency in cycles from registered inputs to c-share outputs.
- RND_DEPTH, 4, random-word FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  issue enable; in-flight operations always complete.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a0, req_a1, req_b0, req_b1  in  NUM_REQ*WIDTH each  operand shares; slice i belongs to requester i.
- rnd_valid  in  1  PRNG word valid.
- rnd_ready  out  1  FIFO can accept.
- rnd_data  in  WIDTH  fresh randomness.
- g_a0, g_a1, g_b0, g_b1, g_r  out  WIDTH each  registered gadget inputs.
- g_c0, g_c1  in  WIDTH each  gadget output shares.
- resp_valid  out  NUM_REQ  one-hot single-cycle response strobe.
- resp_c0, resp_c1  out  WIDTH each  registered result shares.
- busy  out  1  any operation in flight.
- rnd_level  out  clog2(RND_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by the system) clears all outputs to 0:
  - FIFO empty, round-robin pointer = 0, tag pipeline invalid.
  - Consequently rnd_ready = 1 after reset.
- Random FIFO:
  - rnd_ready = !full; push on rnd_valid & rnd_ready.
  - Pop only on issue; issue requires the FIFO to be non-empty at the start of the cycle (no push-to-pop bypass).
  - Simultaneous push and pop when not full: level unchanged.
  - Push attempted while full: not accepted (ready = 0).
- Arbitration:
  - Candidate = first i with req_valid[i], scanning from pointer upward with wrap-around.
  - req_ready[candidate] = en & !empty; all other req_ready = 0.
  - req_ready is combinational from req_valid, en and FIFO state; it never depends on operand values.
  - On accept of requester i, pointer <= (i+1) mod NUM_REQ; otherwise the pointer holds.
- Issue (accept edge k):
  - g_a*/g_b* <= requester-i shares, g_r <= FIFO head.
  - Shares are muxed per share index; share 0 and share 1 never pass through common logic.
  - Tag (valid, i) enters stage 0.
- Idle cycles: g_* <= 0 and no FIFO pop. The gadget then computes zeros that are never reported.
- Tag pipeline: LAT+1 stages.
  - Gadget output is valid after edge k+LAT.
  - resp_c0/c1 <= g_c0/c1 and resp_valid[i] <= 1 at edge k+LAT+1; all values are registered.
  - Latency is 4 cycles with defaults.
  - resp_c* hold the last value when no response is pending; resp_valid is 0.
- Throughput: one operation per cycle while requests and randomness are available. There is no response backpressure; requesters must sink responses.
- busy = OR of tag-pipeline valid bits (including stage 0).
- en low:
  - No new issue; FIFO fill and in-flight drain continue.
  - en rising with pending requests issues in the same cycle.
- Reset mid-operation: in-flight tags are discarded and no responses are produced. FIFO contents are discarded, so randomness is never replayed after reset.

Test Plan:
- Single op: req_valid[2]=1, a=(1,0), b=(0,1), FIFO holds r=1 → req_ready[2]=1 at edge k; resp_valid=0b0100 at edge k+4; resp_c0^resp_c1=1 (a·b); rnd_level drops by 1.
- Round-robin fairness: all four requesters valid continuously, FIFO kept non-empty → grants 0,1,2,3,0,… on consecutive cycles; responses appear in the same order, 4 cycles later, with no bubbles.
- Randomness starvation: FIFO empty, req_valid=0b0001 → req_ready=0 and g_* stay 0. Push one word at edge m → issue no earlier than edge m+1. Two requests with one word → exactly one issues.
- FIFO boundaries: push 5 words with RND_DEPTH=4 and no requests → rnd_ready=0 after the 4th, rnd_level=4, 5th word refused. Simultaneous push and issue when full-1 → level unchanged.
- en gating: two ops issued, then en=0 with requests pending → both responses still arrive, no new req_ready, busy falls 0 after the drain.
- Async reset with 3 ops in flight → all outputs 0 immediately, no resp_valid after release, rnd_level=0, pointer restarts at requester 0.
